// File: rtl/dma_pkg.sv
// Shared types and FIFO sizing for the DMA SRAM read path (also used by dma_dim2).
package dma_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

endpackage

// File: rtl/dma_sfifo.sv
// Show-ahead FIFO of FIFO_DEPTH entries: head entry is visible on rdata_o whenever count_o != 0.
module dma_sfifo
    import dma_pkg::*;
#(
    parameter int W = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     rdata_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally at FIFO_DEPTH because it is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && count_q == '0));
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && count_q == CNT_W'(FIFO_DEPTH)));

endmodule

// File: rtl/dma_sram_rd.sv
// SRAM read engine: address stream in, show-ahead data stream out, with credit-based flow control.
// Optional beat counter enabled by defining DMA_SRAM_RD_CNT_EN.
//
// state  | meaning
// IDLE   | no transfer open; waiting for a beat marked first
// ACTIVE | transfer open; closes when the beat marked last is delivered
module dma_sram_rd
    import dma_pkg::*;
#(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] s_addr,
    input  logic          s_first,
    input  logic          s_last,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] m_data,
    output logic          m_first,
    output logic          m_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic [15:0]   beat_cnt
);

    localparam int FW = DW + 2;

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic             inflight_q, first_d_q, last_d_q;
    logic [CNT_W-1:0] fifo_cnt;
    logic [FW-1:0]    fifo_rdata;
    logic [CNT_W:0]   credit_used;
    logic             m_hs;

    // A read in flight has already claimed a FIFO slot, so it counts against the credit.
    assign credit_used = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q};
    assign s_ready     = !rst && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign mem_en      = s_valid && s_ready;
    assign mem_addr    = s_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            first_d_q  <= 1'b0;
            last_d_q   <= 1'b0;
        end else begin
            inflight_q <= mem_en;
            first_d_q  <= s_first;
            last_d_q   <= s_last;
        end
    end

    dma_sfifo #(.W(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .wdata_i ({mem_rdata, first_d_q, last_d_q}),
        .pop_i   (m_hs),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt)
    );

    assign m_valid = !rst && (fifo_cnt != '0);
    assign m_data  = fifo_rdata[FW-1:2];
    assign m_first = fifo_rdata[1];
    assign m_last  = fifo_rdata[0];
    assign m_hs    = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem_en && s_first) state_d = ACTIVE;
            ACTIVE:  if (m_hs && m_last)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ACTIVE);
        done_d = (state_q == ACTIVE) && m_hs && m_last;
    end

    assign done = done_q;

`ifdef DMA_SRAM_RD_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (m_hs) begin
            if (m_first)                    beat_cnt_d = 16'd1;
            else if (beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) beat_cnt_q <= '0;
        else     beat_cnt_q <= beat_cnt_d;
    end

    assign beat_cnt = beat_cnt_q;
`else
    assign beat_cnt = '0;
`endif

endmodule
